// File: rtl/serial_tx_byte_queue.sv
// serial_tx_byte_queue
//   Small circular byte FIFO in front of the serial write buffer. The
//   controller pushes bytes freely. A launch FSM pops one byte at a time
//   and hands it to the write buffer using the start/data_in/busy
//   handshake. It also flags a write buffer that never raises busy.
//
// Ports
//   sys_clk   : clock, rising edge
//   rst       : async reset, active low
//   wr_en     : push wr_data this cycle
//   wr_data   : byte to queue
//   flush     : sync clear of queued bytes and sticky flags. The in-flight
//               byte is not affected.
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : queued entries (in-flight byte not included)
//   active    : transfer in progress or bytes queued
//   overflow  : sticky, a push was dropped because the FIFO was full
//   ack_err   : sticky, busy never rose within ACK_TIMEOUT cycles of a start
//   buf_start : one-cycle start pulse to the write buffer
//   buf_data  : byte driven to the write buffer data_in
//   buf_busy  : write buffer busy
module serial_tx_byte_queue #(
  parameter int BUF_SIZE    = 8,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [BUF_SIZE-1:0]        wr_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       active,
  output logic                       overflow,
  output logic                       ack_err,
  output logic                       buf_start,
  output logic [BUF_SIZE-1:0]        buf_data,
  input  logic                       buf_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t                          state;
  logic [DEPTH-1:0][BUF_SIZE-1:0]  mem;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [TW-1:0]                   tmo;
  logic                            push, pop, drop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign active = (state != IDLE) || !empty;

  // flush takes priority over both ends of the FIFO. A push into a full
  // FIFO is dropped even when a pop frees a slot in the same cycle, so
  // overflow depends only on the state the producer could see.
  assign pop  = (state == IDLE) && !empty && !flush;
  assign push = wr_en && !flush && !full;
  assign drop = wr_en && !flush && full;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is not reset. Only entries below count are ever read.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // buf_start is set on the IDLE->LAUNCH transition, so it is high for
  // exactly the LAUNCH cycle. buf_data is only loaded on a pop, so it holds
  // through the whole handshake.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      buf_start <= 1'b0;
      buf_data  <= '0;
      tmo       <= '0;
      ack_err   <= 1'b0;
    end else begin
      buf_start <= 1'b0;
      if (flush) ack_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            buf_data  <= mem[rd_ptr];
            buf_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (buf_busy) begin
            state <= WAIT_DONE;
          end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
            // A timeout that lands on a flush cycle still sets ack_err.
            // The byte is abandoned and treated as sent.
            ack_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!buf_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_byte_queue.sv
module tb_serial_tx_byte_queue;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       buf_busy = 1'b0;
  logic       full, empty, active, overflow, ack_err, buf_start;
  logic [2:0] count;
  logic [7:0] buf_data;

  int checks = 0;
  int errors = 0;

  // Write-buffer model: auto mode raises busy one cycle after a start pulse
  // for bfm_len cycles; hold mode pins busy high.
  bit bfm_auto = 1'b0;
  bit bfm_hold = 1'b0;
  int bfm_len = 40;
  int bfm_rem = 0;
  int start_cnt = 0;
  int s0;

  serial_tx_byte_queue #(.BUF_SIZE(8), .DEPTH(4), .ACK_TIMEOUT(4)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .active   (active),
    .overflow (overflow),
    .ack_err  (ack_err),
    .buf_start(buf_start),
    .buf_data (buf_data),
    .buf_busy (buf_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (bfm_hold) buf_busy = 1'b1;
    else if (bfm_rem > 0) begin
      buf_busy = 1'b1;
      bfm_rem--;
    end else buf_busy = 1'b0;
    if (buf_start) begin
      start_cnt++;
      if (bfm_auto) bfm_rem = bfm_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns at negedge+1 of the half cycle in which busy dropped.
  task automatic wait_fall(input string tag);
    bit seen;
    bit ok;
    seen = buf_busy;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      #1;
      if (buf_busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_busy_fall"}, 32'(ok), 32'd1);
  endtask

  task automatic expect_start(input string tag, input logic [7:0] d);
    wait_fall(tag);
    chk({tag, "_active_wd"}, 32'(active), 32'd1);
    step();
    chk({tag, "_no_start_idle"}, 32'(buf_start), 32'd0);
    step();
    chk({tag, "_start"}, 32'(buf_start), 32'd1);
    chk({tag, "_data"}, 32'(buf_data), 32'(d));
  endtask

  task automatic wait_idle(input string tag);
    wait_fall(tag);
    chk({tag, "_active_hi"}, 32'(active), 32'd1);
    step();
    chk({tag, "_active_lo"}, 32'(active), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_start", 32'(buf_start), 32'd0);
    chk("rst_data", 32'(buf_data), 32'd0);
    rst = 1'b1;
    step();

    // 1: single byte, 40-cycle busy
    bfm_auto = 1'b1;
    bfm_len = 40;
    wr_en = 1'b1; wr_data = 8'h9C;
    step();
    wr_en = 1'b0;
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_nostart", 32'(buf_start), 32'd0);
    step();
    chk("t1_start", 32'(buf_start), 32'd1);
    chk("t1_data", 32'(buf_data), 32'h9C);
    step();
    chk("t1_pulse_end", 32'(buf_start), 32'd0);
    chk("t1_data_hold", 32'(buf_data), 32'h9C);
    wait_idle("t1");
    chk("t1_empty", 32'(empty), 32'd1);

    // 2: three consecutive pushes
    bfm_len = 6;
    wr_en = 1'b1; wr_data = 8'h9C;
    step();
    wr_data = 8'hE4;
    step();
    chk("t2_start0", 32'(buf_start), 32'd1);
    chk("t2_data0", 32'(buf_data), 32'h9C);
    wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    chk("t2_count_peak", 32'(count), 32'd2);
    expect_start("t2_b1", 8'hE4);
    expect_start("t2_b2", 8'h5A);
    wait_idle("t2");
    chk("t2_no_ovf", 32'(overflow), 32'd0);

    // 3: busy held, overflow
    bfm_auto = 1'b0;
    bfm_hold = 1'b1;
    wr_en = 1'b1; wr_data = 8'h01;
    step();
    wr_data = 8'h02;
    step();
    chk("t3_start", 32'(buf_start), 32'd1);
    chk("t3_data", 32'(buf_data), 32'h01);
    wr_data = 8'h03; step();
    wr_data = 8'h04; step();
    wr_data = 8'h05; step();
    wr_data = 8'h06; step();
    wr_en = 1'b0;
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    step(); step(); step();
    chk("t3_count_held", 32'(count), 32'd4);
    chk("t3_data_held", 32'(buf_data), 32'h01);
    bfm_len = 3;
    bfm_auto = 1'b1;
    bfm_hold = 1'b0;
    expect_start("t3_b2", 8'h02);
    chk("t3_count_after", 32'(count), 32'd3);
    expect_start("t3_b3", 8'h03);
    expect_start("t3_b4", 8'h04);
    expect_start("t3_b5", 8'h05);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    wait_idle("t3");
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_ovf_sticky2", 32'(overflow), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_ovf_flushed", 32'(overflow), 32'd0);

    // 4: flush while in flight
    bfm_len = 10;
    wr_en = 1'b1; wr_data = 8'hA1;
    step();
    wr_data = 8'hA2;
    step();
    chk("t4_start", 32'(buf_start), 32'd1);
    chk("t4_data", 32'(buf_data), 32'hA1);
    wr_data = 8'hA3;
    step();
    wr_en = 1'b0;
    chk("t4_count", 32'(count), 32'd2);
    s0 = start_cnt;
    step();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_inflight", 32'(active), 32'd1);
    wait_idle("t4");
    repeat (12) step();
    chk("t4_no_more_start", 32'(start_cnt), 32'(s0));
    chk("t4_data_kept", 32'(buf_data), 32'hA1);
    chk("t4_empty_end", 32'(empty), 32'd1);

    // 5: ack timeout
    bfm_auto = 1'b0;
    wr_en = 1'b1; wr_data = 8'h33;
    step();
    wr_en = 1'b0;
    step();
    chk("t5_start", 32'(buf_start), 32'd1);
    chk("t5_data", 32'(buf_data), 32'h33);
    step(); step(); step(); step();
    chk("t5_no_err_yet", 32'(ack_err), 32'd0);
    chk("t5_active", 32'(active), 32'd1);
    step();
    chk("t5_ack_err", 32'(ack_err), 32'd1);
    chk("t5_idle", 32'(active), 32'd0);
    wr_en = 1'b1; wr_data = 8'h44;
    step();
    wr_en = 1'b0;
    step();
    chk("t5_relaunch", 32'(buf_start), 32'd1);
    chk("t5_data2", 32'(buf_data), 32'h44);
    chk("t5_err_sticky", 32'(ack_err), 32'd1);
    repeat (6) step();
    chk("t5_idle2", 32'(active), 32'd0);

    // 6: async reset mid WAIT_DONE
    bfm_hold = 1'b1;
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_data = 8'h20;
    step();
    chk("t6_data", 32'(buf_data), 32'h10);
    wr_data = 8'h30;
    step();
    wr_en = 1'b0;
    step(); step();
    chk("t6_count", 32'(count), 32'd2);
    chk("t6_active", 32'(active), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_full", 32'(full), 32'd0);
    chk("t6_rst_active", 32'(active), 32'd0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    chk("t6_rst_ackerr", 32'(ack_err), 32'd0);
    chk("t6_rst_start", 32'(buf_start), 32'd0);
    chk("t6_rst_data", 32'(buf_data), 32'd0);
    bfm_hold = 1'b0;
    step(); step();
    rst = 1'b1;
    s0 = start_cnt;
    repeat (10) step();
    chk("t6_no_start", 32'(start_cnt), 32'(s0));
    chk("t6_empty", 32'(empty), 32'd1);
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    step();
    chk("t6_new_start", 32'(buf_start), 32'd1);
    chk("t6_new_data", 32'(buf_data), 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_tx_byte_queue.md
Name: serial_tx_byte_queue

Overview:
Upstream feeder for the serial write buffer. It accepts bytes from the MITM control logic into a small circular FIFO. It then launches them one at a time into the write buffer using that buffer's start/data_in/busy handshake. This lets the controller queue several bytes without watching busy. It also detects a write buffer that never acknowledges.

Parameters:
BUF_SIZE, 8, byte width; must equal the BUF_SIZE of the downstream write buffer.
DEPTH, 4, FIFO entries; power of two, at least 2.
ACK_TIMEOUT, 4, sys_clk cycles allowed after a start pulse for busy to rise.

Ports:
sys_clk  in  1  system clock; all logic samples on the rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
wr_en  in  1  push wr_data this cycle.
wr_data  in  BUF_SIZE  byte to queue.
flush  in  1  synchronous clear of queued (not in-flight) bytes and sticky flags.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  $clog2(DEPTH)+1  number of queued entries; excludes the in-flight byte.
active  out  1  FSM not in IDLE, or empty == 0.
overflow  out  1  sticky; set when a push is dropped because the FIFO is full.
ack_err  out  1  sticky; set when ACK_TIMEOUT expires.
buf_start  out  1  one-cycle start pulse to the write buffer.
buf_data  out  BUF_SIZE  byte presented to the write buffer data_in.
buf_busy  in  1  write buffer busy.

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers and count cleared; full=0, empty=1, active=0.
  - overflow=0, ack_err=0, buf_start=0, buf_data=0.
  - FSM to IDLE; timeout counter cleared.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr wrapping modulo DEPTH; count is a registered up/down counter.
  - Push and pop in the same cycle with count in 1..DEPTH-1: count unchanged, both pointers advance.
  - wr_en while full=1: byte dropped and overflow<=1, even if a pop occurs in the same cycle.
- flush:
  - Pointers and count go to 0; overflow and ack_err cleared.
  - Any wr_en in that cycle is ignored and does not set overflow; any pop in that cycle is suppressed.
  - An in-flight byte is not affected; the FSM continues its transfer.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE: if empty=0 and flush=0, pop the head into buf_data, go to LAUNCH.
  - LAUNCH: buf_start=1 for exactly this cycle, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK:
    - buf_busy=1 -> WAIT_DONE.
    - Otherwise increment the counter; on reaching ACK_TIMEOUT, set ack_err<=1 and go to IDLE (byte treated as sent).
  - WAIT_DONE: buf_busy=0 -> IDLE.
- buf_data holds its value from LAUNCH until the next pop; it changes only in IDLE on a pop.
- Latency:
  - Push into an empty FIFO in IDLE at cycle N: count=1 at N+1, pop at N+1, buf_start high at N+2.
  - Consecutive bytes: minimum 2 cycles from buf_busy falling to the next buf_start (WAIT_DONE->IDLE->LAUNCH).
- buf_start is never asserted while buf_busy=1 and the FSM is outside LAUNCH.

Test Plan:
1. After reset, push 0x9C once; the bus-functional write buffer raises busy 1 cycle after start and holds it for 40 cycles -> buf_start pulses exactly 2 cycles after the push, buf_data=0x9C; active stays high until 1 cycle after busy falls, then 0; empty=1.
2. Push 0x9C, 0xE4, 0x5A on consecutive cycles -> count peaks at 2; three buf_start pulses in order 0x9C, 0xE4, 0x5A; each pulse comes 2 cycles after the previous busy fall; no overflow.
3. Hold buf_busy=1, push 0x01..0x06 back-to-back -> 0x01 goes in flight, 0x02..0x05 are queued, full=1, count=4; 0x06 is dropped and overflow=1. Release busy -> 0x02..0x05 are emitted in order; overflow stays 1 until flush.
4. Queue 0xA1, 0xA2, 0xA3; while 0xA1 is in flight (busy=1), pulse flush together with wr_en of 0xFF -> count=0 and overflow=0; 0xA1 transfer completes; no further buf_start occurs and 0xFF is never sent.
5. With busy tied 0, push 0x33 -> buf_start, then ACK_TIMEOUT=4 cycles in WAIT_ACK, then ack_err=1 and FSM in IDLE. A following push of 0x44 still launches.
6. Assert rst=0 asynchronously mid-WAIT_DONE with 2 bytes queued -> outputs go to reset values immediately, without waiting for a clock edge; after release, no buf_start occurs until a new push.
